// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter: the master drives the controls,
// and the counter (slave) returns its count and flags.
interface mod_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output clear, load, load_val, en, up,
        input  q, tc, wrap, ovf
    );

    modport slave (
        input  clear, load, load_val, en, up,
        output q, tc, wrap, ovf
    );
endinterface

// File: rtl/mod_updown_counter.sv
// Synchronous up/down counter with a programmable modulus, clamped parallel load,
// synchronous clear, and optional saturation at the range ends.
module mod_updown_counter #(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter bit     SATURATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    mod_updown_counter_if.slave      bus
);
    // One extra bit so that MODULUS = 2^WIDTH can be represented in the compares
    localparam int             CW      = WIDTH + 1;
    localparam logic [CW-1:0]  MOD_EXT = CW'(MODULUS);
    localparam logic [CW-1:0]  MOD_M1  = CW'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP   = MOD_M1[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_ovf_nxt;
    logic             w_at_top;
    logic             w_at_bot;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_top = ({1'b0, r_q} == MOD_M1);
    assign w_at_bot = (r_q == '0);
    assign w_load_clamped = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : TOP;

    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        w_ovf_nxt  = r_ovf;
        if (bus.clear) begin
            w_q_nxt   = '0;
            w_ovf_nxt = 1'b0;
        end else if (bus.load) begin
            w_q_nxt   = w_load_clamped;
            w_ovf_nxt = 1'b0;
        end else if (bus.en) begin
            if (bus.up) begin
                if (w_at_top) begin
                    w_ovf_nxt = 1'b1;
                    if (!SATURATE) begin
                        w_q_nxt    = '0;
                        w_wrap_nxt = 1'b1;
                    end
                end else begin
                    w_q_nxt = r_q + WIDTH'(1);
                end
            end else begin
                if (w_at_bot) begin
                    w_ovf_nxt = 1'b1;
                    if (!SATURATE) begin
                        w_q_nxt    = TOP;
                        w_wrap_nxt = 1'b1;
                    end
                end else begin
                    w_q_nxt = r_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    // Terminal count is combinational so a cascaded stage sees it on the same edge
    assign bus.tc   = bus.en & ((bus.up & w_at_top) | (~bus.up & w_at_bot));
    assign bus.q    = r_q;
    assign bus.wrap = r_wrap;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: wrapping MODULUS=10 counter, saturating MODULUS=10 counter,
// and a two-stage MODULUS=16 cascade.
module tb_mod_updown_counter;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    int   n_c1_wrap;

    mod_updown_counter_if #(.WIDTH(4)) ifa ();
    mod_updown_counter_if #(.WIDTH(4)) ifs ();
    mod_updown_counter_if #(.WIDTH(4)) ifc0 ();
    mod_updown_counter_if #(.WIDTH(4)) ifc1 ();

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .bus(ifa));
    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .bus(ifs));
    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_c0 (
        .clk(clk), .reset(reset), .bus(ifc0));
    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_c1 (
        .clk(clk), .reset(reset), .bus(ifc1));

    assign ifc1.en = ifc0.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [3:0] v);
        ifa.load = 1'b1; ifa.load_val = v;
        step(1);
        ifa.load = 1'b0;
    endtask

    task automatic load_s(input logic [3:0] v);
        ifs.load = 1'b1; ifs.load_val = v;
        step(1);
        ifs.load = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_c1_wrap = 0;
        reset = 1'b0;
        ifa.clear = 0; ifa.load = 0; ifa.load_val = 0; ifa.en = 0; ifa.up = 1;
        ifs.clear = 0; ifs.load = 0; ifs.load_val = 0; ifs.en = 0; ifs.up = 1;
        ifc0.clear = 0; ifc0.load = 0; ifc0.load_val = 0; ifc0.en = 0; ifc0.up = 1;
        ifc1.clear = 0; ifc1.load = 0; ifc1.load_val = 0; ifc1.up = 1;
        step(2);
        chk("rst_q", ifa.q, 0);
        chk("rst_wrap", ifa.wrap, 0);
        chk("rst_ovf", ifa.ovf, 0);
        reset = 1'b1;

        // count to 7, then asynchronous reset between edges
        ifa.en = 1; ifa.up = 1;
        step(7);
        chk("cnt7", ifa.q, 7);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_q", ifa.q, 0);
        chk("async_rst_wrap", ifa.wrap, 0);
        chk("async_rst_ovf", ifa.ovf, 0);
        #1 reset = 1'b1;
        step(3);
        chk("post_rst_q", ifa.q, 3);

        // up count 0..9 and wrap
        ifa.clear = 1; step(1); ifa.clear = 0;
        chk("clear_q", ifa.q, 0);
        for (int i = 1; i <= 9; i++) begin
            step(1);
            chk("up_q", ifa.q, i);
            if (i == 5) chk("tc_mid", ifa.tc, 0);
        end
        chk("tc_top", ifa.tc, 1);
        chk("ovf_pre_wrap", ifa.ovf, 0);
        step(1);
        chk("upwrap_q", ifa.q, 0);
        chk("upwrap_wrap", ifa.wrap, 1);
        chk("upwrap_ovf", ifa.ovf, 1);
        step(1);
        chk("upwrap_q1", ifa.q, 1);
        chk("wrap_one_cycle", ifa.wrap, 0);
        chk("ovf_sticky", ifa.ovf, 1);

        // down wrap, then direction change
        ifa.en = 0;
        load_a(4'd2);
        chk("ld2_q", ifa.q, 2);
        chk("ld2_ovf", ifa.ovf, 0);
        ifa.en = 1; ifa.up = 0;
        step(1); chk("dn_q1", ifa.q, 1); chk("dn_wrap1", ifa.wrap, 0);
        step(1); chk("dn_q0", ifa.q, 0);
        chk("tc_bot", ifa.tc, 1);
        step(1); chk("dn_q9", ifa.q, 9); chk("dnwrap_wrap", ifa.wrap, 1);
        chk("dnwrap_ovf", ifa.ovf, 1);
        ifa.up = 1;
        step(1); chk("dir_q0", ifa.q, 0); chk("dir_wrap", ifa.wrap, 1);

        // hold, load, clamp and priority
        ifa.en = 0;
        step(1); chk("hold_q", ifa.q, 0); chk("hold_wrap", ifa.wrap, 0);
        chk("hold_ovf", ifa.ovf, 1);
        load_a(4'd5);
        chk("ld5_q", ifa.q, 5); chk("ld5_ovf", ifa.ovf, 0);
        load_a(4'd12);
        chk("ld12_clamp", ifa.q, 9);
        ifa.clear = 1; load_a(4'd5); ifa.clear = 0;
        chk("clr_ld_q", ifa.q, 0);
        load_a(4'd9);
        ifa.en = 1; ifa.up = 1;
        #1 chk("tc_before_ld", ifa.tc, 1);
        load_a(4'd3);
        chk("ld_tc_q", ifa.q, 3); chk("ld_tc_wrap", ifa.wrap, 0);
        chk("ld_tc_ovf", ifa.ovf, 0);
        ifa.en = 0;

        // saturating counter
        load_s(4'd8);
        ifs.en = 1; ifs.up = 1;
        step(1); chk("sat_q_e1", ifs.q, 9); chk("sat_ovf_e1", ifs.ovf, 0);
        for (int i = 2; i <= 4; i++) begin
            step(1);
            chk("sat_q", ifs.q, 9);
            chk("sat_wrap", ifs.wrap, 0);
            chk("sat_ovf", ifs.ovf, 1);
        end
        ifs.en = 0;
        load_s(4'd0);
        ifs.en = 1; ifs.up = 0;
        step(1); chk("sat_dn_q", ifs.q, 0); chk("sat_dn_wrap", ifs.wrap, 0);
        chk("sat_dn_ovf", ifs.ovf, 1);
        step(1); chk("sat_dn_q2", ifs.q, 0);
        ifs.en = 0;

        // two-stage cascade, 256 edges
        ifc0.en = 1; ifc0.up = 1;
        for (int i = 1; i <= 256; i++) begin
            step(1);
            chk("cascade", {24'd0, ifc1.q, ifc0.q}, i % 256);
            if (ifc1.wrap) n_c1_wrap++;
        end
        ifc0.en = 0;
        step(1);
        if (ifc1.wrap) n_c1_wrap++;
        chk("c1_wrap_count", n_c1_wrap, 1);
        chk("c1_ovf", ifc1.ovf, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
